// File: rtl/sw_debounce_if.sv
// Switch bus interface: carries the debounced switch levels and the change pulse from the
// debouncer (master) to the switch/LED bus peripheral (slave).
//
// Parameters:
//   N          - number of switch bits
// Signals:
//   sw         - registered, debounced switch levels
//   sw_changed - one-cycle pulse, high in the cycle any sw bit changed
interface sw_debounce_if #(
  parameter int unsigned N = 8
);
  logic [N-1:0] sw;
  logic         sw_changed;

  modport master (output sw, output sw_changed);
  modport slave  (input  sw, input  sw_changed);
endinterface

// File: rtl/sw_debounce.sv
// Switch debouncer: synchronizes N asynchronous board switches and accepts a new level per bit
// only after it has held for STABLE_CYCLES consecutive clocks.
//
// Build option:
//   SW_DEBOUNCE_EN - when defined, per-bit stability counters are compiled in. When undefined,
//                    sw simply registers the synchronized levels (3-edge latency, no filtering).
//
// Parameters:
//   N             - number of switch bits
//   STABLE_CYCLES - cycles a synchronized level must hold before acceptance (>= 1)
// Ports:
//   clk    - system clock, rising edge
//   rst    - synchronous, active-high reset
//   sw_raw - asynchronous switch levels
//   bus    - master side of sw_debounce_if (sw, sw_changed), all registered outputs
module sw_debounce #(
  parameter int unsigned N             = 8,
  parameter int unsigned STABLE_CYCLES = 1000000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  sw_raw,
  sw_debounce_if.master bus
);

  logic [N-1:0] s1_q, s2_q;
  logic [N-1:0] sw_q, sw_d;
  logic [N-1:0] upd;
  logic         changed_q;

`ifdef SW_DEBOUNCE_EN
  // Counter only needs to reach STABLE_CYCLES-1; keep at least one bit.
  localparam int unsigned CntW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES - 1);

  logic [N-1:0][CntW-1:0] cnt_q, cnt_d;

  // A bit's counter runs only while s2 disagrees with the accepted level; any agreement
  // (including a reversal mid-count) clears it, so excursions never accumulate.
  always_comb begin
    sw_d  = sw_q;
    upd   = '0;
    cnt_d = '0;
    for (int i = 0; i < N; i++) begin
      if (s2_q[i] != sw_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          sw_d[i] = s2_q[i];
          upd[i]  = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_stable_cycles;
  assign unused_stable_cycles = ^STABLE_CYCLES;

  always_comb begin
    sw_d = s2_q;
    upd  = s2_q ^ sw_q;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= '0;
      s2_q      <= '0;
      sw_q      <= '0;
      changed_q <= 1'b0;
    end else begin
      s1_q      <= sw_raw;
      s2_q      <= s1_q;
      sw_q      <= sw_d;
      changed_q <= |upd;
    end
  end

  assign bus.sw         = sw_q;
  assign bus.sw_changed = changed_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce: directed scenarios plus randomized switch activity. A reference model
// works from the history of applied inputs: a bit is accepted when the synchronized level seen
// over the last S edges (none of them at or before a reset) all disagreed with the accepted level.
module tb_sw_debounce;
  localparam int unsigned N = 8;
`ifdef SW_DEBOUNCE_EN
  localparam int S = 4;
`else
  localparam int S = 1;  // plain registering behaves like a one-cycle stability window
`endif
  localparam int MaxE = 4096;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] sw_raw;

  sw_debounce_if #(.N(N)) bus ();

  sw_debounce #(
    .N            (N),
    .STABLE_CYCLES(4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .sw_raw(sw_raw),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] sw;
    logic         ch;
  } exp_t;

  exp_t         expq [$];
  logic [N-1:0] raw_h [MaxE];
  bit           rst_h [MaxE];
  int           t        = 0;
  int           last_rst = -1;
  logic [N-1:0] msw      = '0;
  int           checks   = 0;
  int           errors   = 0;

  // Synchronized level visible to the edge e: input of two edges earlier, zero if a reset
  // cleared the synchronizer in between.
  function automatic logic [N-1:0] s2_seen(input int e);
    if (e < 2) return '0;
    if (rst_h[e-1] || rst_h[e-2]) return '0;
    return raw_h[e-2];
  endfunction

  // Reference model: one expected output per clock edge.
  always @(posedge clk) begin
    logic [N-1:0] upd;
    logic [N-1:0] v;
    bit           ok;
    if (t >= MaxE) begin
      $display("FAIL model_overflow: edge %0d reached, limit %0d", t, MaxE);
      $fatal(1);
    end
    raw_h[t] = sw_raw;
    rst_h[t] = rst;
    if (rst) begin
      msw      = '0;
      last_rst = t;
      expq.push_back({msw, 1'b0});
    end else begin
      upd = '0;
      for (int i = 0; i < int'(N); i++) begin
        ok = (t - S + 1 > last_rst);
        for (int j = 0; j < S; j++) begin
          if (ok) begin
            v = s2_seen(t - j);
            if (v[i] == msw[i]) ok = 0;
          end
        end
        upd[i] = ok;
      end
      msw = msw ^ upd;
      expq.push_back({msw, |upd});
    end
    t++;
  end

  // Monitor: outputs are registered, so compare on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      checks++;
      if (bus.sw !== e.sw || bus.sw_changed !== e.ch) begin
        errors++;
        $display("FAIL outputs at edge %0d: got sw=%h sw_changed=%b, expected sw=%h sw_changed=%b",
                 t - 1, bus.sw, bus.sw_changed, e.sw, e.ch);
      end
    end
  end

  task automatic hold(input logic [N-1:0] v, input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      sw_raw = v;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [N-1:0] cur;
    logic [N-1:0] mask;
    int           len;

    // Reset held two edges with all switches high, then released.
    rst    = 1'b1;
    sw_raw = 8'hFF;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    hold(8'hFF, 10);
    hold(8'h00, 10);

    // Step to 8'h05.
    hold(8'h05, 10);
    hold(8'h00, 10);

    // Three-cycle glitch on bit 3.
    hold(8'h08, 3);
    hold(8'h00, 10);

    // Bit 0 rises, bit 1 one cycle later.
    hold(8'h01, 1);
    hold(8'h03, 10);
    hold(8'h00, 10);

    // Reset in the middle of bit 7's count.
    hold(8'h80, 3);
    pulse_reset();
    hold(8'h80, 10);

    // Single-cycle glitch.
    hold(8'h00, 10);
    hold(8'hA0, 1);
    hold(8'h00, 10);
    hold(8'hA0, 10);

    // Random sparse toggles with random hold lengths and occasional resets.
    cur = 8'hA0;
    repeat (200) begin
      mask = N'($urandom) & N'($urandom);
      cur  = cur ^ mask;
      len  = int'($urandom_range(1, 7));
      hold(cur, len);
      if ($urandom_range(0, 29) == 0) pulse_reset();
    end
    hold(cur, 12);
    hold(8'h00, 12);

    repeat (2) @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
